tree_mac_accumulator: RTL and testbench

//   Downstream stage of the tree MAC core. Consumes the pipelined dot-product stream
//   (sum, row address i, k-tile index k, valid) and accumulates partial sums per row i

---
 rtl/tree_mac_pkg.sv | 16 +
 rtl/tree_mac_out_fifo.sv | 66 ++++++
 rtl/tree_mac_accumulator.sv | 68 ++++++
 tb/tb_tree_mac_accumulator.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tree_mac_pkg.sv
// Shared types and constants for the tree MAC accumulator stage.
package tree_mac_pkg;

  localparam int unsigned DATA_WIDTH_DEF      = 8;
  localparam int unsigned ADDRESS_WIDTH_I_DEF = 8;
  localparam int unsigned FIFO_DEPTH_DEF      = 8;
  localparam int unsigned FIFO_AW             = $clog2(FIFO_DEPTH_DEF);

  // One completed row result as it travels through the output FIFO
  // (default widths; the FIFO itself stores the same layout flattened).
  typedef struct packed {
    logic [DATA_WIDTH_DEF-1:0]      data;
    logic [ADDRESS_WIDTH_I_DEF-1:0] addr_i;
  } result_entry_t;

endpackage

// File: rtl/tree_mac_out_fifo.sv
// Show-ahead output FIFO for completed row results. A push that meets a
// full FIFO is dropped and flags a sticky overflow, unless the same edge
// also pops, in which case the push is accepted.
module tree_mac_out_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       out_rdy,
  output logic [WIDTH-1:0]           head_data,
  output logic                       head_val,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);
  import tree_mac_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_q;
  logic             ovf_q;
  logic             full;
  logic             pop;
  logic             push_ok;

  // Handshake decode; a pop on the same edge frees the slot a full push needs
  always_comb begin
    full    = (count_q == (AW+1)'(DEPTH));
    pop     = (count_q != '0) && out_rdy;
    push_ok = push && (!full || pop);
  end

  // Storage, pointers, occupancy and sticky overflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned n = 0; n < DEPTH; n++) mem[n] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (push && !push_ok) ovf_q <= 1'b1;
    end
  end

  assign head_data = mem[rd_ptr];
  assign head_val  = (count_q != '0);
  assign count     = count_q;
  assign overflow  = ovf_q;

endmodule

// File: rtl/tree_mac_accumulator.sv
// Per-row accumulation of the MAC dot-product stream across K tiles; each
// finished row is queued in the output FIFO for writeback.
module tree_mac_accumulator #(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned ADDRESS_WIDTH_I = 8,
  parameter int unsigned ADDRESS_WIDTH_K = 8,
  parameter int unsigned K_TILES         = 4,
  parameter int unsigned FIFO_DEPTH      = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_WIDTH-1:0]         sum_in,
  input  logic [ADDRESS_WIDTH_I-1:0]    addr_i_in,
  input  logic [ADDRESS_WIDTH_K-1:0]    addr_k_in,
  input  logic                          val_in,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [ADDRESS_WIDTH_I-1:0]    out_addr_i,
  output logic                          out_val,
  input  logic                          out_rdy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);
  import tree_mac_pkg::*;

  localparam int unsigned ROWS  = 2 ** ADDRESS_WIDTH_I;
  localparam int unsigned EW    = DATA_WIDTH + ADDRESS_WIDTH_I;
  localparam logic [ADDRESS_WIDTH_K-1:0] LAST_K = ADDRESS_WIDTH_K'(K_TILES - 1);

  logic [DATA_WIDTH-1:0] acc [ROWS];
  logic [DATA_WIDTH-1:0] nxt;
  logic                  push;
  logic [EW-1:0]         head;

  // Next partial: k=0 (or single-tile mode) restarts the row instead of adding
  always_comb begin
    if (K_TILES == 1 || addr_k_in == '0) nxt = sum_in;
    else                                 nxt = acc[addr_i_in] + sum_in;
    push = val_in && (K_TILES == 1 || addr_k_in == LAST_K);
  end

  // Row accumulator array; combinational read lets same-row inputs chain every cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned r = 0; r < ROWS; r++) acc[r] <= '0;
    end else if (val_in) begin
      acc[addr_i_in] <= nxt;
    end
  end

  tree_mac_out_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({nxt, addr_i_in}),
    .out_rdy   (out_rdy),
    .head_data (head),
    .head_val  (out_val),
    .count     (fifo_count),
    .overflow  (overflow)
  );

  assign out_data   = head[EW-1 -: DATA_WIDTH];
  assign out_addr_i = head[ADDRESS_WIDTH_I-1:0];

endmodule

// File: tb/tb_tree_mac_accumulator.sv
// Bench for tree_mac_accumulator: a K_TILES=4 instance for directed row
// tests and a K_TILES=1 instance for randomized streaming, each compared
// every cycle against a queue-based model of the row/FIFO behaviour.
module tb_tree_mac_accumulator;
  import tree_mac_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // K_TILES=4 instance
  logic [7:0] s4 = '0, i4 = '0, k4 = '0;
  logic       v4 = 1'b0, r4 = 1'b0;
  logic [7:0] od4, oa4;
  logic       ov4, of4;
  logic [3:0] oc4;

  // K_TILES=1 instance
  logic [7:0] s1 = '0, i1 = '0, k1 = '0;
  logic       v1 = 1'b0, r1 = 1'b0;
  logic [7:0] od1, oa1;
  logic       ov1, of1;
  logic [3:0] oc1;

  tree_mac_accumulator #(
    .DATA_WIDTH(8), .ADDRESS_WIDTH_I(8), .ADDRESS_WIDTH_K(8), .K_TILES(4), .FIFO_DEPTH(8)
  ) u4 (
    .clk(clk), .reset(rst), .sum_in(s4), .addr_i_in(i4), .addr_k_in(k4), .val_in(v4),
    .out_data(od4), .out_addr_i(oa4), .out_val(ov4), .out_rdy(r4),
    .fifo_count(oc4), .overflow(of4)
  );

  tree_mac_accumulator #(
    .DATA_WIDTH(8), .ADDRESS_WIDTH_I(8), .ADDRESS_WIDTH_K(8), .K_TILES(1), .FIFO_DEPTH(8)
  ) u1 (
    .clk(clk), .reset(rst), .sum_in(s1), .addr_i_in(i1), .addr_k_in(k1), .val_in(v1),
    .out_data(od1), .out_addr_i(oa1), .out_val(ov1), .out_rdy(r1),
    .fifo_count(oc1), .overflow(of1)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // ---------------- behavioural models ----------------
  logic [7:0]    m4_acc [256];
  result_entry_t q4[$];
  bit            m4_of = 1'b0;
  result_entry_t q1[$];
  bit            m1_of = 1'b0;

  always @(posedge clk or posedge rst) begin : model4
    bit         full, pop;
    logic [7:0] nx;
    if (rst) begin
      q4.delete();
      m4_of = 1'b0;
      for (int r = 0; r < 256; r++) m4_acc[r] = 8'd0;
    end else begin
      full = (q4.size() == 8);
      pop  = (q4.size() != 0) && r4;
      if (pop) void'(q4.pop_front());
      if (v4) begin
        if (k4 == 8'd0) nx = s4;
        else            nx = 8'((int'(m4_acc[i4]) + int'(s4)) % 256);
        m4_acc[i4] = nx;
        if (k4 == 8'd3) begin
          if (!full || pop) q4.push_back('{data: nx, addr_i: i4});
          else              m4_of = 1'b1;
        end
      end
    end
  end

  always @(posedge clk or posedge rst) begin : model1
    bit full, pop;
    if (rst) begin
      q1.delete();
      m1_of = 1'b0;
    end else begin
      full = (q1.size() == 8);
      pop  = (q1.size() != 0) && r1;
      if (pop) void'(q1.pop_front());
      if (v1) begin
        if (!full || pop) q1.push_back('{data: s1, addr_i: i1});
        else              m1_of = 1'b1;
      end
    end
  end

  // Per-cycle comparison of both instances against their models
  always @(negedge clk) begin
    if (!rst) begin
      chk("val4", 32'(ov4), 32'(q4.size() != 0));
      chk("cnt4", 32'(oc4), 32'(q4.size()));
      chk("ovf4", 32'(of4), 32'(m4_of));
      if (q4.size() != 0) begin
        chk("data4", 32'(od4), 32'(q4[0].data));
        chk("addr4", 32'(oa4), 32'(q4[0].addr_i));
      end
      chk("val1", 32'(ov1), 32'(q1.size() != 0));
      chk("cnt1", 32'(oc1), 32'(q1.size()));
      chk("ovf1", 32'(of1), 32'(m1_of));
      if (q1.size() != 0) begin
        chk("data1", 32'(od1), 32'(q1[0].data));
        chk("addr1", 32'(oa1), 32'(q1[0].addr_i));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic d4(input logic [7:0] i, input logic [7:0] k, input logic [7:0] s);
    v4 = 1'b1; i4 = i; k4 = k; s4 = s;
    @(posedge clk); #2;
    v4 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #2;
    end
  endtask

  task automatic row4(input logic [7:0] i, input logic [7:0] s0);
    d4(i, 8'd0, s0);
    d4(i, 8'd1, 8'd0);
    d4(i, 8'd2, 8'd0);
    d4(i, 8'd3, 8'd0);
  endtask

  task automatic reset_pulse();
    // asserted between edges; outputs must clear without a clock
    rst = 1'b1;
    #1;
    chk("rst_val4",  32'(ov4), 32'd0);
    chk("rst_cnt4",  32'(oc4), 32'd0);
    chk("rst_ovf4",  32'(of4), 32'd0);
    chk("rst_data4", 32'(od4), 32'd0);
    chk("rst_addr4", 32'(oa4), 32'd0);
    chk("rst_val1",  32'(ov1), 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  initial begin
    #1;
    @(posedge clk); #2;
    reset_pulse();
    r4 = 1'b1;

    // 1+2+3+4 on row 3
    d4(8'd3, 8'd0, 8'd1);
    d4(8'd3, 8'd1, 8'd2);
    d4(8'd3, 8'd2, 8'd3);
    d4(8'd3, 8'd3, 8'd4);
    chk("t1_val",  32'(ov4), 32'd1);
    chk("t1_data", 32'(od4), 32'd10);
    chk("t1_addr", 32'(oa4), 32'd3);

    // row reuse: k=0 overwrites
    d4(8'd3, 8'd0, 8'd5);
    d4(8'd3, 8'd1, 8'd0);
    d4(8'd3, 8'd2, 8'd0);
    d4(8'd3, 8'd3, 8'd0);
    chk("t2_data", 32'(od4), 32'd5);

    // interleaved rows with wrap on row 1
    d4(8'd1, 8'd0, 8'd200);
    d4(8'd2, 8'd0, 8'd7);
    d4(8'd1, 8'd1, 8'd100);
    d4(8'd2, 8'd1, 8'd8);
    d4(8'd1, 8'd2, 8'd0);
    d4(8'd2, 8'd2, 8'd9);
    d4(8'd1, 8'd3, 8'd0);
    chk("t3_data1", 32'(od4), 32'd44);
    chk("t3_addr1", 32'(oa4), 32'd1);
    d4(8'd2, 8'd3, 8'd10);
    chk("t3_data2", 32'(od4), 32'd34);
    chk("t3_addr2", 32'(oa4), 32'd2);
    chk("t3_cnt",   32'(oc4), 32'd1);

    // tile index beyond K_TILES-1 accumulates without pushing
    d4(8'd4, 8'd0, 8'd1);
    d4(8'd4, 8'd5, 8'd2);
    chk("t4_nopush", 32'(ov4), 32'd0);
    d4(8'd4, 8'd3, 8'd3);
    chk("t4_data", 32'(od4), 32'd6);
    idle(1);

    // fill with consumer stalled, then one more completion
    r4 = 1'b0;
    for (int n = 0; n < 8; n++) row4(8'(10 + n), 8'(n));
    chk("t5_cnt8", 32'(oc4), 32'd8);
    chk("t5_ovf0", 32'(of4), 32'd0);
    row4(8'd30, 8'd99);
    chk("t5_cnt", 32'(oc4), 32'd8);
    chk("t5_ovf", 32'(of4), 32'd1);
    chk("t5_head", 32'(od4), 32'd0);
    r4 = 1'b1;
    idle(10);
    chk("t5_drained", 32'(oc4), 32'd0);

    reset_pulse();

    // full FIFO, push coincides with pop: accepted
    r4 = 1'b0;
    for (int n = 0; n < 8; n++) row4(8'(10 + n), 8'(n));
    d4(8'd20, 8'd0, 8'd9);
    d4(8'd20, 8'd1, 8'd0);
    d4(8'd20, 8'd2, 8'd0);
    r4 = 1'b1;
    d4(8'd20, 8'd3, 8'd0);
    chk("t6_cnt", 32'(oc4), 32'd8);
    chk("t6_ovf", 32'(of4), 32'd0);
    chk("t6_head", 32'(od4), 32'd1);
    idle(10);
    chk("t6_drained", 32'(oc4), 32'd0);

    // single-tile streaming with random consumer readiness
    for (int c = 0; c < 300; c++) begin
      v1 = 1'($urandom_range(0, 1));
      s1 = 8'($urandom);
      i1 = 8'($urandom);
      k1 = 8'd0;
      r1 = ($urandom_range(0, 3) != 0);
      @(posedge clk); #2;
    end
    v1 = 1'b0;
    r1 = 1'b1;
    idle(12);
    chk("t7_drained", 32'(oc1), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
